// File: rtl/ita_hwpe_cfg_master.sv
// Config-port initiator for the ITA HWPE: acquires a context, writes one job's registers and the
// trigger, then polls status until idle. One peripheral transaction is outstanding at a time.
module ita_hwpe_cfg_master #(
    parameter int unsigned N_REGS     = 17,
    parameter logic [31:0] REG_OFFSET = 32'h20,
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned MASTER_ID  = 0,
    parameter int unsigned POLL_GAP   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [N_REGS*32-1:0]   job_regs_i,
    input  logic                   clear_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic [7:0]             job_id_o,
    output logic                   periph_req_o,
    input  logic                   periph_gnt_i,
    output logic [31:0]            periph_add_o,
    output logic                   periph_wen_o,
    output logic [3:0]             periph_be_o,
    output logic [31:0]            periph_data_o,
    output logic [ID_WIDTH-1:0]    periph_id_o,
    input  logic                   periph_r_valid_i,
    input  logic [31:0]            periph_r_data_i,
    input  logic [ID_WIDTH-1:0]    periph_r_id_i
);

    localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [GAP_W-1:0]    LAST_GAP = GAP_W'(POLL_GAP - 1);
    localparam logic [ID_WIDTH-1:0] MY_ID    = ID_WIDTH'(MASTER_ID);
    localparam logic [31:0]         ADDR_TRIG = 32'h00;
    localparam logic [31:0]         ADDR_ACQ  = 32'h04;
    localparam logic [31:0]         ADDR_STAT = 32'h0C;

    typedef enum logic [3:0] {
        IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR_REQ, WR_RSP,
        TRIG_REQ, TRIG_RSP, GAP, STAT_REQ, STAT_RSP, DONE
    } state_e;

    state_e            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic              r_abort;
    logic [31:0]       r_regs [N_REGS];

    logic              w_rsp;
    logic              w_abort;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [31:0]       w_wr_add;

    assign w_rsp     = periph_r_valid_i && (periph_r_id_i == MY_ID);
    assign w_abort   = r_abort || clear_i;
    assign w_idx_nxt = r_idx + IDX_W'(1);
    assign w_wr_add  = REG_OFFSET + (32'(w_idx_nxt) << 2);

    assign periph_be_o = 4'hF;
    assign periph_id_o = MY_ID;

    // Job words are plain data: captured at accept, never reset.
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && job_valid_i) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                r_regs[i] <= job_regs_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_gap         <= '0;
            r_abort       <= 1'b0;
            job_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            aborted_o     <= 1'b0;
            job_id_o      <= 8'h00;
            periph_req_o  <= 1'b0;
            periph_add_o  <= 32'h0;
            periph_wen_o  <= 1'b1;
            periph_data_o <= 32'h0;
        end else begin
            done_o <= 1'b0;
            if (r_state != IDLE && clear_i) r_abort <= 1'b1;
            case (r_state)
                IDLE: if (job_valid_i) begin
                    r_idx        <= '0;
                    r_abort      <= 1'b0;
                    job_ready_o  <= 1'b0;
                    busy_o       <= 1'b1;
                    periph_req_o <= 1'b1;
                    periph_add_o <= ADDR_ACQ;
                    periph_wen_o <= 1'b1;
                    r_state      <= ACQ_REQ;
                end
                // The acquire request is the only one that may be withdrawn before grant.
                ACQ_REQ: if (periph_gnt_i) begin
                    periph_req_o <= 1'b0;
                    r_state      <= ACQ_RSP;
                end else if (w_abort) begin
                    periph_req_o <= 1'b0;
                    done_o       <= 1'b1;
                    aborted_o    <= 1'b1;
                    r_state      <= DONE;
                end
                ACQ_RSP: if (w_rsp) begin
                    if (w_abort) begin
                        done_o    <= 1'b1;
                        aborted_o <= 1'b1;
                        r_state   <= DONE;
                    end else if (periph_r_data_i[31]) begin
                        r_gap   <= '0;
                        r_state <= BACKOFF;
                    end else begin
                        job_id_o      <= periph_r_data_i[7:0];
                        periph_req_o  <= 1'b1;
                        periph_add_o  <= REG_OFFSET;
                        periph_wen_o  <= 1'b0;
                        periph_data_o <= r_regs[0];
                        r_state       <= WR_REQ;
                    end
                end
                BACKOFF: if (w_abort) begin
                    done_o    <= 1'b1;
                    aborted_o <= 1'b1;
                    r_state   <= DONE;
                end else if (r_gap == LAST_GAP) begin
                    periph_req_o <= 1'b1;
                    periph_add_o <= ADDR_ACQ;
                    periph_wen_o <= 1'b1;
                    r_state      <= ACQ_REQ;
                end else begin
                    r_gap <= r_gap + GAP_W'(1);
                end
                WR_REQ: if (periph_gnt_i) begin
                    periph_req_o <= 1'b0;
                    r_state      <= WR_RSP;
                end
                WR_RSP: if (w_rsp) begin
                    if (w_abort) begin
                        done_o    <= 1'b1;
                        aborted_o <= 1'b1;
                        r_state   <= DONE;
                    end else if (r_idx == LAST_IDX) begin
                        periph_req_o  <= 1'b1;
                        periph_add_o  <= ADDR_TRIG;
                        periph_data_o <= 32'h0;
                        r_state       <= TRIG_REQ;
                    end else begin
                        r_idx         <= w_idx_nxt;
                        periph_req_o  <= 1'b1;
                        periph_add_o  <= w_wr_add;
                        periph_data_o <= r_regs[w_idx_nxt];
                        r_state       <= WR_REQ;
                    end
                end
                TRIG_REQ: if (periph_gnt_i) begin
                    periph_req_o <= 1'b0;
                    r_state      <= TRIG_RSP;
                end
                TRIG_RSP: if (w_rsp) begin
                    if (w_abort) begin
                        done_o    <= 1'b1;
                        aborted_o <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_gap   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: if (w_abort) begin
                    done_o    <= 1'b1;
                    aborted_o <= 1'b1;
                    r_state   <= DONE;
                end else if (r_gap == LAST_GAP) begin
                    periph_req_o <= 1'b1;
                    periph_add_o <= ADDR_STAT;
                    periph_wen_o <= 1'b1;
                    r_state      <= STAT_REQ;
                end else begin
                    r_gap <= r_gap + GAP_W'(1);
                end
                STAT_REQ: if (periph_gnt_i) begin
                    periph_req_o <= 1'b0;
                    r_state      <= STAT_RSP;
                end
                // A pending abort wins over a final idle status.
                STAT_RSP: if (w_rsp) begin
                    if (w_abort || periph_r_data_i == 32'h0) begin
                        done_o    <= 1'b1;
                        aborted_o <= w_abort;
                        r_state   <= DONE;
                    end else begin
                        r_gap   <= '0;
                        r_state <= GAP;
                    end
                end
                DONE: begin
                    aborted_o   <= 1'b0;
                    job_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ita_hwpe_cfg_master.sv
// Directed bench for ita_hwpe_cfg_master with a small behavioural config-slave that logs every
// granted transaction and returns queued read data.
module tb_ita_hwpe_cfg_master;

    localparam int unsigned N_REGS    = 3;
    localparam int unsigned ID_WIDTH  = 5;
    localparam int unsigned MASTER_ID = 0;
    localparam int unsigned POLL_GAP  = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  job_valid_i;
    logic                  job_ready_o;
    logic [N_REGS*32-1:0]  job_regs_i;
    logic                  clear_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  aborted_o;
    logic [7:0]            job_id_o;
    logic                  periph_req_o;
    logic                  periph_gnt_i;
    logic [31:0]           periph_add_o;
    logic                  periph_wen_o;
    logic [3:0]            periph_be_o;
    logic [31:0]           periph_data_o;
    logic [ID_WIDTH-1:0]   periph_id_o;
    logic                  periph_r_valid_i;
    logic [31:0]           periph_r_data_i;
    logic [ID_WIDTH-1:0]   periph_r_id_i;

    ita_hwpe_cfg_master #(
        .N_REGS(N_REGS), .REG_OFFSET(32'h20), .ID_WIDTH(ID_WIDTH),
        .MASTER_ID(MASTER_ID), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
        .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .job_id_o(job_id_o),
        .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
        .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o), .periph_r_valid_i(periph_r_valid_i),
        .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Slave model state
    logic [31:0] acq_q[$];
    logic [31:0] stat_q[$];
    logic [31:0] log_add[$];
    logic        log_wen[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          wr_dly = 0;
    bit          foreign = 1'b0;
    int          done_cnt = 0;
    logic [7:0]  last_id = 8'h00;
    logic        last_ab = 1'b0;
    int          drop_err = 0;

    initial begin
        bit          pend, pend_stat, waiting;
        logic [31:0] pend_data, h_add, h_data, rd;
        int          wcnt, dly;
        pend = 0; pend_stat = 0; waiting = 0; wcnt = 0;
        pend_data = 0; h_add = 0; h_data = 0;
        periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = 0;
        periph_r_id_i = ID_WIDTH'(MASTER_ID);
        forever begin
            @(negedge clk_i);
            cyc++;
            if (done_o) begin
                done_cnt++;
                last_id = job_id_o;
                last_ab = aborted_o;
            end
            periph_r_valid_i = 0;
            periph_r_id_i    = ID_WIDTH'(MASTER_ID);
            periph_r_data_i  = 0;
            periph_gnt_i     = 0;
            if (!rst_ni) begin
                pend = 0; waiting = 0; wcnt = 0;
            end else begin
                if (pend) begin
                    periph_r_valid_i = 1;
                    if (foreign && pend_stat) begin
                        periph_r_id_i = ID_WIDTH'(MASTER_ID + 1);
                        foreign = 0;
                    end else begin
                        periph_r_data_i = pend_data;
                        pend = 0;
                    end
                end
                if (periph_req_o) begin
                    if (!waiting) begin
                        waiting = 1; wcnt = 0;
                        h_add = periph_add_o; h_data = periph_data_o;
                    end
                    dly = periph_wen_o ? 0 : wr_dly;
                    if (wcnt >= dly) begin
                        periph_gnt_i = 1;
                        waiting = 0;
                        if (dly > 0) begin
                            chk("hold_add", periph_add_o, h_add);
                            chk("hold_data", periph_data_o, h_data);
                        end
                        log_add.push_back(periph_add_o);
                        log_wen.push_back(periph_wen_o);
                        log_data.push_back(periph_data_o);
                        log_cyc.push_back(cyc);
                        rd = 32'h0;
                        if (periph_wen_o && periph_add_o == 32'h04)
                            rd = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
                        else if (periph_wen_o && periph_add_o == 32'h0C)
                            rd = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                        pend = 1;
                        pend_stat = periph_wen_o && (periph_add_o == 32'h0C);
                        pend_data = rd;
                    end else begin
                        wcnt++;
                    end
                end else if (waiting) begin
                    drop_err++;
                    waiting = 0;
                end
            end
        end
    end

    task automatic clear_log();
        log_add.delete(); log_wen.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic chk_txn(input int i, input logic [31:0] add, input logic wen,
                           input logic [31:0] data);
        if (i < log_add.size()) begin
            chk($sformatf("txn%0d_add", i), log_add[i], add);
            chk($sformatf("txn%0d_wen", i), 32'(log_wen[i]), 32'(wen));
            if (!wen) chk($sformatf("txn%0d_data", i), log_data[i], data);
        end else begin
            chk($sformatf("txn%0d_missing", i), 32'(log_add.size()), 32'(i + 1));
        end
    endtask

    task automatic run_job(input logic [N_REGS*32-1:0] regs);
        int t;
        job_regs_i = regs;
        t = 0;
        while (!job_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk("ready_before_job", 32'(job_ready_o), 32'd1);
        job_valid_i = 1;
        @(negedge clk_i);
        job_valid_i = 0;
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        chk("ready_after_accept", 32'(job_ready_o), 32'd0);
    endtask

    task automatic wait_done(input int start);
        int t;
        t = 0;
        while (done_cnt == start && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        chk("done_seen", 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        int start, t;
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, t;
        rst_ni = 0; job_valid_i = 0; clear_i = 0; job_regs_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_req", 32'(periph_req_o), 32'd0);
        chk("rst_wen", 32'(periph_wen_o), 32'd1);
        chk("rst_be", 32'(periph_be_o), 32'hF);
        chk("rst_id", 32'(periph_id_o), MASTER_ID);
        chk("rst_ready", 32'(job_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_jobid", 32'(job_id_o), 32'd0);
        chk("rst_add", periph_add_o, 32'd0);
        rst_ni = 1;
        repeat (2) @(negedge clk_i);

        // 1: nominal job
        clear_log();
        acq_q = '{32'h2}; stat_q = '{32'h1, 32'h1, 32'h0};
        start = done_cnt;
        run_job({32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        wait_done(start);
        chk("t1_jobid", 32'(last_id), 32'h2);
        chk("t1_aborted", 32'(last_ab), 32'd0);
        chk("t1_ntxn", 32'(log_add.size()), 32'd8);
        chk_txn(0, 32'h04, 1'b1, 32'h0);
        chk_txn(1, 32'h20, 1'b0, 32'hAAAA_0001);
        chk_txn(2, 32'h24, 1'b0, 32'hBBBB_0002);
        chk_txn(3, 32'h28, 1'b0, 32'hCCCC_0003);
        chk_txn(4, 32'h00, 1'b0, 32'h0);
        chk_txn(5, 32'h0C, 1'b1, 32'h0);
        chk_txn(7, 32'h0C, 1'b1, 32'h0);
        if (log_cyc.size() >= 2) chk("t1_latency", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
        repeat (10) @(negedge clk_i);
        chk("t1_single_done", 32'(done_cnt - start), 32'd1);
        chk("t1_idle_busy", 32'(busy_o), 32'd0);

        // 2: acquire retries with backoff
        clear_log();
        acq_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3}; stat_q = '{32'h0};
        start = done_cnt;
        run_job({32'h3, 32'h2, 32'h1});
        wait_done(start);
        chk_txn(0, 32'h04, 1'b1, 32'h0);
        chk_txn(1, 32'h04, 1'b1, 32'h0);
        chk_txn(2, 32'h04, 1'b1, 32'h0);
        chk_txn(3, 32'h20, 1'b0, 32'h1);
        if (log_cyc.size() >= 3) begin
            chk("t2_retry_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'(POLL_GAP + 2));
            chk("t2_retry_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'(POLL_GAP + 2));
        end
        chk("t2_jobid", 32'(last_id), 32'h3);

        // 3: delayed write grants
        clear_log();
        wr_dly = 5;
        acq_q = '{32'h5}; stat_q = '{32'h0};
        start = done_cnt;
        run_job({32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        wait_done(start);
        wr_dly = 0;
        chk_txn(1, 32'h20, 1'b0, 32'h1111_1111);
        chk_txn(2, 32'h24, 1'b0, 32'h2222_2222);
        chk_txn(3, 32'h28, 1'b0, 32'h3333_3333);
        chk_txn(4, 32'h00, 1'b0, 32'h0);
        if (log_cyc.size() >= 3) chk("t3_wr_spacing", 32'(log_cyc[2] - log_cyc[1]), 32'd7);
        chk("t3_no_drop", 32'(drop_err), 32'd0);

        // 4: foreign-id response ignored
        clear_log();
        foreign = 1;
        acq_q = '{32'h9}; stat_q = '{32'h1, 32'h0};
        start = done_cnt;
        run_job({32'h3, 32'h2, 32'h1});
        wait_done(start);
        chk("t4_ntxn", 32'(log_add.size()), 32'd7);
        chk_txn(6, 32'h0C, 1'b1, 32'h0);
        chk("t4_jobid", 32'(last_id), 32'h9);
        chk("t4_aborted", 32'(last_ab), 32'd0);

        // 5: clear while a write waits for grant
        clear_log();
        wr_dly = 5;
        acq_q = '{32'h7}; stat_q = '{32'h0};
        start = done_cnt;
        run_job({32'h3, 32'h2, 32'hDEAD_BEEF});
        t = 0;
        while (!(periph_req_o && !periph_wen_o) && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        clear_i = 1;
        @(negedge clk_i);
        clear_i = 0;
        wait_done(start);
        wr_dly = 0;
        chk("t5_aborted", 32'(last_ab), 32'd1);
        chk("t5_jobid", 32'(last_id), 32'h7);
        chk("t5_ntxn", 32'(log_add.size()), 32'd2);
        chk_txn(1, 32'h20, 1'b0, 32'hDEAD_BEEF);
        chk("t5_no_drop", 32'(drop_err), 32'd0);

        // 6: async reset during status polling gap
        clear_log();
        acq_q = '{32'h4}; stat_q = '{32'h1, 32'h1, 32'h1, 32'h1};
        start = done_cnt;
        run_job({32'h3, 32'h2, 32'h1});
        t = 0;
        while (log_add.size() < 5 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk("t6_trig_seen", 32'(log_add.size()), 32'd5);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 0;
        #1;
        chk("t6_req", 32'(periph_req_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_ready", 32'(job_ready_o), 32'd1);
        acq_q.delete(); stat_q.delete();
        @(negedge clk_i);
        rst_ni = 1;
        repeat (5) @(negedge clk_i);
        chk("t6_no_done", 32'(done_cnt - start), 32'd0);
        clear_log();
        acq_q = '{32'h6}; stat_q = '{32'h0};
        run_job({32'h3, 32'h2, 32'h1});
        wait_done(start);
        chk("t6_jobid", 32'(last_id), 32'h6);
        chk("t6_aborted", 32'(last_ab), 32'd0);
        chk_txn(0, 32'h04, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
